// File: rtl/tx_source_pkg.sv
// Shared definitions for the tx source arbiter: arbitration modes and the
// helper that sizes channel-index fields.
package tx_source_pkg;

    typedef enum logic [1:0] {
        MODE_FIXED  = 2'd0,
        MODE_RR     = 2'd1,
        MODE_FORCED = 2'd2
    } arb_mode_e;

    function automatic int sel_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

endpackage

// File: rtl/tx_source_arbiter_rr_grant.sv
// Combinational grant finder: picks the first requester at or after a base
// index (round-robin), or the lowest requester otherwise.
module rr_grant
    import tx_source_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int SEL_W    = 2
) (
    input  logic [CHANNELS-1:0] req,
    input  logic [SEL_W-1:0]    base,
    input  arb_mode_e           mode,
    output logic [CHANNELS-1:0] gnt,
    output logic [SEL_W-1:0]    gnt_idx,
    output logic                any_req
);

    always_comb begin
        int start_idx;
        int idx;
        gnt       = '0;
        gnt_idx   = '0;
        any_req   = 1'b0;
        start_idx = 0;
        idx       = 0;
        // Only round-robin rotates the search; other modes scan from 0.
        if (mode == MODE_RR && int'(base) < CHANNELS) begin
            start_idx = int'(base);
        end
        for (int k = 0; k < CHANNELS; k++) begin
            idx = start_idx + k;
            if (idx >= CHANNELS) begin
                idx = idx - CHANNELS;
            end
            if (!any_req && req[idx]) begin
                any_req = 1'b1;
                gnt_idx = SEL_W'(idx);
            end
        end
        if (any_req) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/tx_source_arbiter.sv
// Selects one of CHANNELS word sources into a one-entry output register with
// valid/ready handshakes on every channel and on the output.
module tx_source_arbiter
    import tx_source_pkg::*;
#(
    parameter  int LENGTH   = 32,
    parameter  int CHANNELS = 4,
    parameter  int MODE     = 0,
    localparam int SEL_W    = sel_width(CHANNELS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [SEL_W-1:0]           sel,
    input  logic [CHANNELS-1:0]        in_valid,
    input  logic [CHANNELS*LENGTH-1:0] in_data,
    output logic [CHANNELS-1:0]        in_ready,
    output logic                       out_valid,
    output logic [LENGTH-1:0]          out_data,
    output logic [SEL_W-1:0]           out_ch,
    input  logic                       out_ready
);

    localparam arb_mode_e MODE_E = arb_mode_e'(MODE[1:0]);

    logic                r_out_valid;
    logic [LENGTH-1:0]   r_out_data;
    logic [SEL_W-1:0]    r_out_ch;
    logic [SEL_W-1:0]    r_ptr;

    logic [CHANNELS-1:0] w_eligible;
    logic [CHANNELS-1:0] w_gnt;
    logic [SEL_W-1:0]    w_gnt_idx;
    logic                w_any;
    logic                w_space;
    logic                w_accept;
    logic [LENGTH-1:0]   w_sel_data;
    logic [SEL_W-1:0]    w_base;

    always_comb begin
        w_eligible = '0;
        if (MODE_E == MODE_FORCED) begin
            // An out-of-range sel simply leaves nothing eligible.
            if (int'(sel) < CHANNELS) begin
                w_eligible[sel] = in_valid[sel];
            end
        end else begin
            w_eligible = in_valid;
        end
    end

    assign w_base = (MODE_E == MODE_RR) ? r_ptr : '0;

    rr_grant #(
        .CHANNELS (CHANNELS),
        .SEL_W    (SEL_W)
    ) u_rr_grant (
        .req     (w_eligible),
        .base    (w_base),
        .mode    (MODE_E),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any_req (w_any)
    );

    assign w_space    = !r_out_valid || out_ready;
    // Gating with rst keeps every in_ready low while reset is held.
    assign w_accept   = rst && enable && w_space && w_any;
    assign in_ready   = w_accept ? w_gnt : '0;
    assign w_sel_data = in_data[int'(w_gnt_idx)*LENGTH +: LENGTH];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; the data register is reset too because its
    // reset value is architecturally visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            r_ptr       <= '0;
        end else begin
            if (w_accept) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_ch    <= w_gnt_idx;
                if (MODE_E == MODE_RR) begin
                    r_ptr <= (int'(w_gnt_idx) == CHANNELS - 1) ? '0
                                                              : w_gnt_idx + SEL_W'(1);
                end
            end else if (r_out_valid && out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_tx_source_arbiter.sv
// Directed bench: three arbiter instances (fixed priority, round-robin,
// forced select on five channels so an out-of-range sel is expressible).
module tb_tx_source_arbiter;

    logic clk;
    logic rst;

    // Fixed priority, 4 channels
    logic        fp_enable, fp_out_ready, fp_out_valid;
    logic [1:0]  fp_sel, fp_out_ch;
    logic [3:0]  fp_in_valid, fp_in_ready;
    logic [127:0] fp_in_data;
    logic [31:0] fp_out_data;

    // Round-robin, 4 channels
    logic        rr_enable, rr_out_ready, rr_out_valid;
    logic [1:0]  rr_sel, rr_out_ch;
    logic [3:0]  rr_in_valid, rr_in_ready;
    logic [127:0] rr_in_data;
    logic [31:0] rr_out_data;

    // Forced select, 5 channels
    logic        fs_enable, fs_out_ready, fs_out_valid;
    logic [2:0]  fs_sel, fs_out_ch;
    logic [4:0]  fs_in_valid, fs_in_ready;
    logic [159:0] fs_in_data;
    logic [31:0] fs_out_data;

    int n_checks = 0;
    int n_fail   = 0;

    tx_source_arbiter #(.LENGTH(32), .CHANNELS(4), .MODE(0)) u_fp (
        .clk(clk), .rst(rst), .enable(fp_enable), .sel(fp_sel),
        .in_valid(fp_in_valid), .in_data(fp_in_data), .in_ready(fp_in_ready),
        .out_valid(fp_out_valid), .out_data(fp_out_data), .out_ch(fp_out_ch),
        .out_ready(fp_out_ready)
    );

    tx_source_arbiter #(.LENGTH(32), .CHANNELS(4), .MODE(1)) u_rr (
        .clk(clk), .rst(rst), .enable(rr_enable), .sel(rr_sel),
        .in_valid(rr_in_valid), .in_data(rr_in_data), .in_ready(rr_in_ready),
        .out_valid(rr_out_valid), .out_data(rr_out_data), .out_ch(rr_out_ch),
        .out_ready(rr_out_ready)
    );

    tx_source_arbiter #(.LENGTH(32), .CHANNELS(5), .MODE(2)) u_fs (
        .clk(clk), .rst(rst), .enable(fs_enable), .sel(fs_sel),
        .in_valid(fs_in_valid), .in_data(fs_in_data), .in_ready(fs_in_ready),
        .out_valid(fs_out_valid), .out_data(fs_out_data), .out_ch(fs_out_ch),
        .out_ready(fs_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b0;
        fp_enable = 1'b1; fp_out_ready = 1'b1; fp_sel = '0; fp_in_valid = 4'b1111;
        rr_enable = 1'b1; rr_out_ready = 1'b1; rr_sel = '0; rr_in_valid = '0;
        fs_enable = 1'b1; fs_out_ready = 1'b1; fs_sel = '0; fs_in_valid = '0;
        fp_in_data = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        rr_in_data = '0;
        fs_in_data = '0;

        // Reset held with all fixed-priority channels valid
        tick();
        tick();
        chk("rst_out_valid", fp_out_valid, 0);
        chk("rst_out_data", fp_out_data, 0);
        chk("rst_in_ready", fp_in_ready, 0);
        chk("rst_out_ch", fp_out_ch, 0);

        rst = 1'b1;
        #1;
        chk("post_rst_in_ready", fp_in_ready, 4'b0001);
        tick();
        chk("first_valid", fp_out_valid, 1);
        chk("first_ch", fp_out_ch, 0);
        chk("first_data", fp_out_data, 32'hA0);

        // Fixed priority: lowest index wins
        fp_in_valid = 4'b1010;
        fp_in_data  = {32'h33, 32'h0, 32'h11, 32'h0};
        #1;
        chk("fp_in_ready_1010", fp_in_ready, 4'b0010);
        tick();
        chk("fp_data_ch1", fp_out_data, 32'h11);
        chk("fp_ch1", fp_out_ch, 1);
        fp_in_valid = 4'b1000;
        #1;
        chk("fp_in_ready_1000", fp_in_ready, 4'b1000);
        tick();
        chk("fp_data_ch3", fp_out_data, 32'h33);
        chk("fp_ch3", fp_out_ch, 3);
        fp_in_valid = 4'b0000;
        tick();
        chk("fp_drained", fp_out_valid, 0);
        chk("fp_drain_keeps_data", fp_out_data, 32'h33);

        // Backpressure then same-cycle drain and reload
        fp_in_valid = 4'b0100;
        fp_in_data  = {32'h0, 32'hDEADBEEF, 32'h0, 32'h5A5A};
        tick();
        chk("bp_capture", fp_out_data, 32'hDEADBEEF);
        chk("bp_capture_ch", fp_out_ch, 2);
        fp_out_ready = 1'b0;
        fp_in_valid  = 4'b0101;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_in_ready", fp_in_ready, 0);
            tick();
            chk("bp_hold_data", fp_out_data, 32'hDEADBEEF);
            chk("bp_hold_valid", fp_out_valid, 1);
        end
        fp_out_ready = 1'b1;
        fp_in_valid  = 4'b0001;
        #1;
        chk("reload_in_ready", fp_in_ready, 4'b0001);
        tick();
        chk("reload_valid", fp_out_valid, 1);
        chk("reload_data", fp_out_data, 32'h5A5A);
        chk("reload_ch", fp_out_ch, 0);
        fp_in_valid = 4'b0000;
        tick();
        chk("reload_drained", fp_out_valid, 0);

        // Round-robin: all channels valid, one word per cycle
        for (int i = 0; i < 4; i++) rr_in_data[i*32 +: 32] = 32'h100 + i;
        rr_in_valid = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("rr_in_ready", rr_in_ready, 4'b0001 << (i % 4));
            tick();
            chk("rr_out_ch", rr_out_ch, i % 4);
            chk("rr_out_data", rr_out_data, 32'h100 + (i % 4));
            chk("rr_out_valid", rr_out_valid, 1);
        end
        // enable low: no accept, held word drains, pointer frozen at 0
        rr_enable = 1'b0;
        #1;
        chk("rr_dis_in_ready", rr_in_ready, 0);
        tick();
        chk("rr_dis_drain", rr_out_valid, 0);
        rr_enable   = 1'b1;
        rr_in_valid = 4'b1010;
        #1;
        chk("rr_skip_in_ready", rr_in_ready, 4'b0010);
        tick();
        chk("rr_skip_ch", rr_out_ch, 1);
        rr_in_valid = 4'b1111;
        #1;
        chk("rr_after1_in_ready", rr_in_ready, 4'b0100);
        tick();
        chk("rr_after1_ch", rr_out_ch, 2);

        // Forced select on 5 channels
        fs_in_data  = {32'h44, 32'h33, 32'h22, 32'h11, 32'h00};
        fs_sel      = 3'd2;
        fs_in_valid = 5'b00010;
        #1;
        chk("fs_wrong_ch_in_ready", fs_in_ready, 0);
        tick();
        chk("fs_wrong_ch_valid", fs_out_valid, 0);
        fs_sel      = 3'd5;
        fs_in_valid = 5'b11111;
        #1;
        chk("fs_oob_in_ready", fs_in_ready, 0);
        tick();
        chk("fs_oob_valid", fs_out_valid, 0);
        fs_sel = 3'd4;
        #1;
        chk("fs_sel4_in_ready", fs_in_ready, 5'b10000);
        tick();
        chk("fs_sel4_data", fs_out_data, 32'h44);
        chk("fs_sel4_ch", fs_out_ch, 4);
        fs_enable = 1'b0;
        #1;
        chk("fs_dis_in_ready", fs_in_ready, 0);
        tick();
        chk("fs_dis_drain", fs_out_valid, 0);
        chk("fs_dis_keep_data", fs_out_data, 32'h44);

        // Async reset mid-hold: round-robin holds ch2 with pointer at 3
        rr_out_ready = 1'b0;
        tick();
        chk("rr_hold_valid", rr_out_valid, 1);
        chk("rr_hold_data", rr_out_data, 32'h102);
        #3;
        rst = 1'b0;
        #1;
        chk("async_rst_valid", rr_out_valid, 0);
        chk("async_rst_ch", rr_out_ch, 0);
        chk("async_rst_in_ready", rr_in_ready, 0);
        tick();
        rst = 1'b1;
        rr_out_ready = 1'b1;
        #1;
        chk("rr_ptr_cleared", rr_in_ready, 4'b0001);
        tick();
        chk("rr_ptr_cleared_ch", rr_out_ch, 0);
        chk("rr_ptr_cleared_data", rr_out_data, 32'h100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
